// File: rtl/ctb_int_broadcaster.sv
// rtl/ctb_int_broadcaster.sv - integer CTB producer: tracks ALU/MUL/DIV latency and broadcasts PRF tags
`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module ctb_int_broadcaster #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 16
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   flush,
  input  logic [`ISSUE_WIDTH_INT-1:0]                            issue_valid,
  input  logic [`ISSUE_WIDTH_INT-1:0][1:0]                       issue_fu,
  input  logic [`ISSUE_WIDTH_INT-1:0]                            issue_rd_write,
  input  logic [`ISSUE_WIDTH_INT-1:0][`PRF_INT_INDEX_SIZE-1:0]   issue_rd_index,
  output logic [`ISSUE_WIDTH_INT-1:0]                            ctb_valid,
  output logic [`ISSUE_WIDTH_INT-1:0][`PRF_INT_INDEX_SIZE-1:0]   ctb_prf_int_index,
  output logic [`ISSUE_WIDTH_INT-1:0]                            ex_busy,
  output logic                                                   err
);

  localparam int W  = `ISSUE_WIDTH_INT;
  localparam int IW = `PRF_INT_INDEX_SIZE;
  localparam int CW = $clog2(DIV_LATENCY) + 1;
  localparam logic [1:0] FU_MUL = 2'd2;
  localparam logic [1:0] FU_DIV = 2'd3;

  typedef enum logic {IDLE, BUSY} div_state_t;

  logic [MUL_LATENCY-1:1] s_valid;
  logic [MUL_LATENCY-1:1] s_write;
  logic [IW-1:0]          s_index [MUL_LATENCY-1:1];

  div_state_t    div_state;
  logic [CW-1:0] cnt;
  logic          div_write;
  logic [IW-1:0] div_index;

  logic [W-1:0] accept, is_mul, is_div, wrong_pipe, alu;
  logic         violation;

  // Pipe 1 is blocked while its last MUL stage is about to claim the CTB port; pipe 2 while a DIV iterates.
  assign ex_busy = {div_state == BUSY, s_valid[MUL_LATENCY-1], 1'b0};

  always_comb begin
    accept     = '0;
    is_mul     = '0;
    is_div     = '0;
    wrong_pipe = '0;
    alu        = '0;
    for (int i = 0; i < W; i++) begin
      accept[i]     = issue_valid[i] && !flush && !ex_busy[i];
      is_mul[i]     = (i == 1) && (issue_fu[i] == FU_MUL);
      is_div[i]     = (i == 2) && (issue_fu[i] == FU_DIV);
      wrong_pipe[i] = ((issue_fu[i] == FU_MUL) && (i != 1)) || ((issue_fu[i] == FU_DIV) && (i != 2));
      alu[i]        = accept[i] && !is_mul[i] && !is_div[i];
    end
  end

  assign violation = |(issue_valid & {W{!flush}} & (ex_busy | wrong_pipe));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctb_valid         <= '0;
      ctb_prf_int_index <= '0;
      err               <= 1'b0;
      s_valid           <= '0;
      s_write           <= '0;
      for (int k = 1; k < MUL_LATENCY; k++) s_index[k] <= '0;
      div_state         <= IDLE;
      cnt               <= '0;
      div_write         <= 1'b0;
      div_index         <= '0;
    end else begin
      err       <= violation;
      ctb_valid <= '0;
      if (flush) begin
        s_valid   <= '0;
        div_state <= IDLE;
        cnt       <= '0;
      end else begin
        s_valid[1] <= accept[1] && is_mul[1];
        s_write[1] <= issue_rd_write[1];
        s_index[1] <= issue_rd_index[1];
        for (int k = 2; k < MUL_LATENCY; k++) begin
          s_valid[k] <= s_valid[k-1];
          s_write[k] <= s_write[k-1];
          s_index[k] <= s_index[k-1];
        end

        for (int i = 0; i < W; i++) begin
          if (alu[i] && issue_rd_write[i]) begin
            ctb_valid[i]         <= 1'b1;
            ctb_prf_int_index[i] <= issue_rd_index[i];
          end
        end

        if (s_valid[MUL_LATENCY-1] && s_write[MUL_LATENCY-1]) begin
          ctb_valid[1]         <= 1'b1;
          ctb_prf_int_index[1] <= s_index[MUL_LATENCY-1];
        end

        case (div_state)
          IDLE: begin
            if (accept[2] && is_div[2]) begin
              div_state <= BUSY;
              cnt       <= CW'(DIV_LATENCY - 1);
              div_write <= issue_rd_write[2];
              div_index <= issue_rd_index[2];
            end
          end
          BUSY: begin
            if (cnt == CW'(1)) begin
              if (div_write) begin
                ctb_valid[2]         <= 1'b1;
                ctb_prf_int_index[2] <= div_index;
              end
              div_state <= IDLE;
              cnt       <= '0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: div_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctb_int_broadcaster.sv
// tb/tb_ctb_int_broadcaster.sv - bench for ctb_int_broadcaster: vector table, corner sequences, random vs reference model
`ifndef ISSUE_WIDTH_INT
`define ISSUE_WIDTH_INT 3
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module tb_ctb_int_broadcaster;
  localparam int ML = 3;
  localparam int DL = 16;
  localparam int W  = `ISSUE_WIDTH_INT;
  localparam int IW = `PRF_INT_INDEX_SIZE;
  localparam logic [1:0] ALU = 2'd0, BR = 2'd1, MUL = 2'd2, DIV = 2'd3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [W-1:0]             issue_valid;
  logic [W-1:0][1:0]        issue_fu;
  logic [W-1:0]             issue_rd_write;
  logic [W-1:0][IW-1:0]     issue_rd_index;
  logic [W-1:0]             ctb_valid;
  logic [W-1:0][IW-1:0]     ctb_prf_int_index;
  logic [W-1:0]             ex_busy;
  logic                     err;

  int n_tests = 0;
  int n_fail  = 0;

  ctb_int_broadcaster #(.MUL_LATENCY(ML), .DIV_LATENCY(DL)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_rd_write(issue_rd_write), .issue_rd_index(issue_rd_index),
    .ctb_valid(ctb_valid), .ctb_prf_int_index(ctb_prf_int_index),
    .ex_busy(ex_busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              fl;
    logic [W-1:0]      v;
    logic [W-1:0][1:0] fu;
    logic [W-1:0]      wr;
    logic [W-1:0][IW-1:0] idx;
    logic [W-1:0]      ev;
    logic [W-1:0][IW-1:0] eidx;
    logic              eerr;
  } vec_t;

  vec_t vt [8];

  function automatic logic [W-1:0][IW-1:0] tags(int a2, int a1, int a0);
    logic [W-1:0][IW-1:0] r;
    r[2] = IW'(a2);
    r[1] = IW'(a1);
    r[0] = IW'(a0);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    issue_valid    = '0;
    issue_fu       = '0;
    issue_rd_write = '0;
    issue_rd_index = '0;
  endtask

  task automatic issue(int p, logic [1:0] fu, logic wr, int idx);
    issue_valid[p]    = 1'b1;
    issue_fu[p]       = fu;
    issue_rd_write[p] = wr;
    issue_rd_index[p] = IW'(idx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: per-port schedule of future broadcasts, indexed by absolute cycle.
  task automatic run_random(int ncyc);
    bit                   sv   [W][256];
    logic [IW-1:0]        sidx [W][256];
    bit                   mres [256];
    int                   div_end;
    logic [W-1:0][IW-1:0] last_idx;
    logic                 err_next;
    int                   cyc;
    int                   c;
    logic [W-1:0]         ev, eb;
    logic                 e;
    for (int p = 0; p < W; p++) for (int j = 0; j < 256; j++) sv[p][j] = 0;
    for (int j = 0; j < 256; j++) mres[j] = 0;
    div_end  = 0;
    last_idx = '0;
    err_next = 1'b0;
    cyc      = 0;
    idle_inputs();
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      c = cyc % 256;
      for (int p = 0; p < W; p++) begin
        ev[p] = sv[p][c];
        if (sv[p][c]) last_idx[p] = sidx[p][c];
        sv[p][c] = 0;
      end
      eb = {div_end > cyc, mres[(cyc + 1) % 256], 1'b0};
      chk("rnd ctb_valid", ctb_valid, ev);
      chk("rnd ctb_index", ctb_prf_int_index, last_idx);
      chk("rnd ex_busy", ex_busy, eb);
      chk("rnd err", err, err_next);
      mres[c] = 0;

      idle_inputs();
      flush = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < W; p++) begin
        if ($urandom_range(0, 1) == 1)
          issue(p, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, (1 << IW) - 1));
      end

      if (flush) begin
        for (int p = 0; p < W; p++) for (int j = 0; j < 256; j++) sv[p][j] = 0;
        for (int j = 0; j < 256; j++) mres[j] = 0;
        div_end  = 0;
        err_next = 1'b0;
      end else begin
        e = 1'b0;
        for (int p = 0; p < W; p++) begin
          if (issue_valid[p]) begin
            if (eb[p]) begin
              e = 1'b1;
            end else if (issue_fu[p] == MUL && p == 1) begin
              mres[(cyc + ML) % 256] = 1;
              if (issue_rd_write[p]) begin
                sv[1][(cyc + ML) % 256]   = 1;
                sidx[1][(cyc + ML) % 256] = issue_rd_index[p];
              end
            end else if (issue_fu[p] == DIV && p == 2) begin
              div_end = cyc + DL;
              if (issue_rd_write[p]) begin
                sv[2][(cyc + DL) % 256]   = 1;
                sidx[2][(cyc + DL) % 256] = issue_rd_index[p];
              end
            end else begin
              if (issue_fu[p] == MUL || issue_fu[p] == DIV) e = 1'b1;
              if (issue_rd_write[p]) begin
                sv[p][(cyc + 1) % 256]   = 1;
                sidx[p][(cyc + 1) % 256] = issue_rd_index[p];
              end
            end
          end
        end
        err_next = e;
      end
      tick();
      cyc++;
    end
    idle_inputs();
  endtask

  initial begin
    int bad_busy, bad_v;
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("reset ctb_valid", ctb_valid, 0);
    chk("reset ctb_index", ctb_prf_int_index, 0);
    chk("reset ex_busy", ex_busy, 0);
    chk("reset err", err, 0);
    tick();
    tick();
    reset = 1'b0;

    // Reset and ALU on all pipes
    repeat (8) tick();
    issue(0, ALU, 1, 5); issue(1, ALU, 1, 6); issue(2, ALU, 1, 7);
    tick();
    idle_inputs();
    chk("alu3 ctb_valid", ctb_valid, 3'b111);
    chk("alu3 ctb_index", ctb_prf_int_index, tags(7, 6, 5));
    chk("alu3 err", err, 0);
    tick();
    chk("alu3 pulse end", ctb_valid, 0);
    chk("alu3 index hold", ctb_prf_int_index, tags(7, 6, 5));

    vt[0] = '{1'b0, 3'b111, {BR, BR, BR},   3'b111, tags(12, 11, 10), 3'b111, tags(12, 11, 10), 1'b0};
    vt[1] = '{1'b0, 3'b001, {ALU, ALU, ALU}, 3'b000, tags(0, 0, 33),   3'b000, tags(12, 11, 10), 1'b0};
    vt[2] = '{1'b0, 3'b001, {ALU, ALU, MUL}, 3'b001, tags(0, 0, 40),   3'b001, tags(12, 11, 40), 1'b1};
    vt[3] = '{1'b0, 3'b010, {ALU, DIV, ALU}, 3'b010, tags(0, 41, 0),   3'b010, tags(12, 41, 40), 1'b1};
    vt[4] = '{1'b0, 3'b100, {MUL, ALU, ALU}, 3'b100, tags(42, 0, 0),   3'b100, tags(42, 41, 40), 1'b1};
    vt[5] = '{1'b0, 3'b000, {ALU, ALU, ALU}, 3'b111, tags(1, 2, 3),    3'b000, tags(42, 41, 40), 1'b0};
    vt[6] = '{1'b1, 3'b111, {ALU, ALU, ALU}, 3'b111, tags(50, 51, 52), 3'b000, tags(42, 41, 40), 1'b0};
    vt[7] = '{1'b0, 3'b010, {ALU, ALU, ALU}, 3'b010, tags(0, 127, 0),  3'b010, tags(42, 127, 40), 1'b0};
    for (int i = 0; i < 8; i++) begin
      flush          = vt[i].fl;
      issue_valid    = vt[i].v;
      issue_fu       = vt[i].fu;
      issue_rd_write = vt[i].wr;
      issue_rd_index = vt[i].idx;
      tick();
      chk($sformatf("vec%0d ctb_valid", i), ctb_valid, vt[i].ev);
      chk($sformatf("vec%0d ctb_index", i), ctb_prf_int_index, vt[i].eidx);
      chk($sformatf("vec%0d err", i), err, vt[i].eerr);
    end
    idle_inputs();
    tick();

    // MUL pipelining
    issue(1, MUL, 1, 9);
    tick();
    idle_inputs();
    chk("mul t+1 busy", ex_busy[1], 0);
    issue(1, MUL, 1, 10);
    tick();
    idle_inputs();
    chk("mul t+2 busy", ex_busy[1], 1);
    chk("mul t+2 valid", ctb_valid[1], 0);
    issue(1, ALU, 1, 11);
    tick();
    idle_inputs();
    chk("mul t+3 valid", ctb_valid[1], 1);
    chk("mul t+3 index", ctb_prf_int_index[1], 9);
    chk("mul t+3 err", err, 1);
    chk("mul t+3 busy", ex_busy[1], 1);
    tick();
    chk("mul t+4 valid", ctb_valid[1], 1);
    chk("mul t+4 index", ctb_prf_int_index[1], 10);
    chk("mul t+4 err", err, 0);
    chk("mul t+4 busy", ex_busy[1], 0);
    tick();
    chk("mul dropped alu", ctb_valid[1], 0);
    chk("mul dropped index", ctb_prf_int_index[1], 10);

    // DIV FSM with a blocked ALU mid-flight and back-to-back divide
    issue(2, DIV, 1, 20);
    bad_busy = 0;
    bad_v = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      idle_inputs();
      if (ex_busy[2] !== 1'b1) bad_busy++;
      if (ctb_valid[2] !== 1'b0) bad_v++;
      if (k == 6) chk("div blocked alu err", err, 1);
      if (k == 5) issue(2, ALU, 1, 99);
    end
    chk("div busy window", bad_busy, 0);
    chk("div no early bcast", bad_v, 0);
    tick();
    chk("div t+16 valid", ctb_valid[2], 1);
    chk("div t+16 index", ctb_prf_int_index[2], 20);
    chk("div t+16 busy", ex_busy[2], 0);
    issue(2, DIV, 1, 21);
    tick();
    idle_inputs();
    chk("div2 t+1 busy", ex_busy[2], 1);
    repeat (14) tick();
    chk("div2 t+15 valid", ctb_valid[2], 0);
    tick();
    chk("div2 t+16 valid", ctb_valid[2], 1);
    chk("div2 t+16 index", ctb_prf_int_index[2], 21);

    // No-write MUL still reserves the port
    issue(1, MUL, 0, 70);
    tick();
    idle_inputs();
    tick();
    chk("mul nowr busy", ex_busy[1], 1);
    tick();
    chk("mul nowr valid", ctb_valid[1], 0);
    chk("mul nowr index", ctb_prf_int_index[1], 10);

    // Flush with DIV busy and two MULs in flight
    issue(2, DIV, 1, 30); issue(1, MUL, 1, 31);
    tick();
    idle_inputs();
    issue(1, MUL, 1, 32); issue(0, ALU, 1, 34);
    tick();
    idle_inputs();
    chk("flush pre bcast", ctb_valid, 3'b001);
    chk("flush pre busy", ex_busy, 3'b110);
    flush = 1'b1;
    issue(0, ALU, 1, 33);
    tick();
    idle_inputs();
    chk("flush f+1 valid", ctb_valid, 0);
    chk("flush f+1 busy", ex_busy, 0);
    chk("flush f+1 err", err, 0);
    bad_v = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ctb_valid !== '0) bad_v++;
    end
    chk("flush no later bcast", bad_v, 0);

    // Asynchronous reset mid-DIV
    issue(2, DIV, 1, 40);
    tick();
    idle_inputs();
    tick();
    tick();
    issue(0, ALU, 1, 45);
    tick();
    idle_inputs();
    chk("arst pre valid", ctb_valid, 3'b001);
    #3;
    reset = 1'b1;
    #1;
    chk("arst ctb_valid", ctb_valid, 0);
    chk("arst ctb_index", ctb_prf_int_index, 0);
    chk("arst ex_busy", ex_busy, 0);
    chk("arst err", err, 0);
    tick();
    reset = 1'b0;
    issue(2, DIV, 1, 41);
    tick();
    idle_inputs();
    chk("arst div busy", ex_busy[2], 1);
    repeat (15) tick();
    chk("arst div valid", ctb_valid[2], 1);
    chk("arst div index", ctb_prf_int_index[2], 41);

    run_random(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
